// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write FIFO between M stage and slow data memory; `define STB_FWD_EN forwards load hits instead of stalling
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              stall_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic [PW:0] count;
  logic full, enq, pop, hit;
  assign full = count == (PW+1)'(DEPTH);
  assign enq = st_valid_i && !full;
  assign pop = state == REQ && mem_ack_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(enq) - (PW+1)'(pop);
      state <= state == IDLE ? (count != '0 ? REQ : IDLE)
                             : (pop && count == (PW+1)'(1) ? IDLE : REQ);
    end
  always_ff @(posedge clk)
    if (enq) begin
      addr_q[wr_ptr] <= st_addr_i;
      data_q[wr_ptr] <= st_data_i;
    end
`ifdef STB_FWD_EN
  logic [DATA_W-1:0] fwd_data;
`endif
  // Scan oldest to youngest so the last hit is the youngest matching store
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STB_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((PW+1)'(i) < count && addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) begin
        hit = 1'b1;
`ifdef STB_FWD_EN
        fwd_data = data_q[idx];
`endif
      end
    end
  end
  assign mem_req_o   = state == REQ;
  assign mem_addr_o  = addr_q[rd_ptr];
  assign mem_data_o  = data_q[rd_ptr];
  assign empty_o     = count == '0;
  assign mem_raddr_o = ld_addr_i;
`ifdef STB_FWD_EN
  assign ld_data_o = ld_valid_i && hit ? fwd_data : mem_rdata_i;
  assign stall_o   = st_valid_i && full;
`else
  assign ld_data_o = mem_rdata_i;
  assign stall_o   = (st_valid_i && full) || (ld_valid_i && hit);
`endif
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
  logic clk = 0, rst = 1;
  logic st_valid = 0, ld_valid = 0, mem_ack = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [31:0] ld_data, mem_raddr, mem_rdata, mem_addr, mem_data;
  logic stall, empty, mem_req;
  int vecs = 0, errs = 0;
  logic [31:0] log_a[$], log_d[$];
  dmem_store_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_o(ld_data),
    .stall_o(stall), .empty_o(empty), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_ack_i(mem_ack)
  );
  always #5 clk = ~clk;
  assign mem_rdata = ~mem_raddr;
  // Inputs are stable at the falling edge, so a req+ack seen here is accepted at the next rise
  always @(negedge clk)
    if (mem_req && mem_ack) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_data);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1;
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b exp 0", mem_req); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", empty); end
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", stall); end
    tick;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 32'h80 + 32'(4 * i); st_data = 32'(i);
      tick;
    end
    st_valid = 0;
    #1;
    vecs++; if (mem_req !== 1'b1 || dut.count !== 3'd3) begin errs++; $display("FAIL pre_rst got req=%b count=%0d exp req=1 count=3", mem_req, dut.count); end
    #2 rst = 1;
    #1;
    vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL async_rst_req got %b exp 0", mem_req); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL async_rst_empty got %b exp 1", empty); end
    tick;
    rst = 0;
    tick;
    vecs++; if (empty !== 1'b1 || mem_req !== 1'b0 || log_a.size() != 0) begin errs++; $display("FAIL post_rst got empty=%b req=%b writes=%0d exp 1 0 0", empty, mem_req, log_a.size()); end
  endtask
  task automatic test_single;
    log_a.delete(); log_d.delete();
    st_valid = 1; st_addr = 32'h100; st_data = 32'hDEADBEEF;
    tick;
    st_valid = 0;
    #1;
    vecs++; if (mem_req !== 1'b0 || empty !== 1'b0) begin errs++; $display("FAIL single_k1 got req=%b empty=%b exp 0 0", mem_req, empty); end
    tick;
    vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_data !== 32'hDEADBEEF) begin errs++; $display("FAIL single_k2 got req=%b %h/%h exp 1 00000100/deadbeef", mem_req, mem_addr, mem_data); end
    tick;
    vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_data !== 32'hDEADBEEF) begin errs++; $display("FAIL single_hold got req=%b %h/%h exp 1 00000100/deadbeef", mem_req, mem_addr, mem_data); end
    tick;
    mem_ack = 1;
    tick;
    mem_ack = 0;
    #1;
    vecs++; if (mem_req !== 1'b0 || empty !== 1'b1) begin errs++; $display("FAIL single_pop got req=%b empty=%b exp 0 1", mem_req, empty); end
    vecs++; if (log_a.size() != 1 || log_a[0] !== 32'h100 || log_d[0] !== 32'hDEADBEEF) begin errs++; $display("FAIL single_write got n=%0d exp 1 write 00000100/deadbeef", log_a.size()); end
  endtask
  task automatic test_full;
    log_a.delete(); log_d.delete();
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h300 + 32'(4 * i); st_data = 32'h1000 + 32'(i);
      tick;
    end
    st_addr = 32'h310; st_data = 32'h1004;
    #1;
    vecs++; if (stall !== 1'b1 || dut.count !== 3'd4) begin errs++; $display("FAIL full_stall got stall=%b count=%0d exp 1 4", stall, dut.count); end
    tick;
    vecs++; if (stall !== 1'b1 || dut.count !== 3'd4) begin errs++; $display("FAIL full_hold got stall=%b count=%0d exp 1 4", stall, dut.count); end
    mem_ack = 1;
    tick;
    mem_ack = 0;
    #1;
    vecs++; if (stall !== 1'b0 || dut.count !== 3'd3) begin errs++; $display("FAIL full_pop got stall=%b count=%0d exp 0 3", stall, dut.count); end
    tick;
    vecs++; if (dut.count !== 3'd4) begin errs++; $display("FAIL full_accept got count=%0d exp 4", dut.count); end
    st_valid = 0; mem_ack = 1;
    for (int n = 0; n < 20 && !empty; n++) tick;
    mem_ack = 0;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL full_drain_timeout got empty=%b exp 1", empty); end
    vecs++; if (log_a.size() != 5) begin errs++; $display("FAIL full_nwrites got %0d exp 5", log_a.size()); end
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      vecs++;
      if (log_a[i] !== 32'h300 + 32'(4 * i) || log_d[i] !== 32'h1000 + 32'(i)) begin
        errs++; $display("FAIL full_order[%0d] got %h/%h exp %h/%h", i, log_a[i], log_d[i], 32'h300 + 32'(4 * i), 32'h1000 + 32'(i));
      end
    end
  endtask
  task automatic test_load_hit;
    log_a.delete(); log_d.delete();
    st_valid = 1; st_addr = 32'h200; st_data = 32'h11;
    tick;
    st_data = 32'h22;
    tick;
    st_valid = 0; ld_valid = 1; ld_addr = 32'h204;
    #1;
    vecs++; if (stall !== 1'b0 || ld_data !== ~32'h204) begin errs++; $display("FAIL ld_miss got stall=%b data=%h exp 0 %h", stall, ld_data, ~32'h204); end
    vecs++; if (mem_raddr !== 32'h204) begin errs++; $display("FAIL ld_raddr got %h exp 00000204", mem_raddr); end
`ifdef STB_FWD_EN
    ld_addr = 32'h202;
    #1;
    vecs++; if (stall !== 1'b0 || ld_data !== 32'h22) begin errs++; $display("FAIL ld_fwd got stall=%b data=%h exp 0 00000022", stall, ld_data); end
    tick;
    vecs++; if (stall !== 1'b0 || ld_data !== 32'h22) begin errs++; $display("FAIL ld_fwd_hold got stall=%b data=%h exp 0 00000022", stall, ld_data); end
    mem_ack = 1;
    for (int n = 0; n < 10 && !empty; n++) tick;
    mem_ack = 0;
    vecs++; if (empty !== 1'b1 || ld_data !== ~32'h202) begin errs++; $display("FAIL ld_fwd_drained got empty=%b data=%h exp 1 %h", empty, ld_data, ~32'h202); end
`else
    ld_addr = 32'h200;
    #1;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL ld_stall got %b exp 1", stall); end
    tick;
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL ld_stall_hold got %b exp 1", stall); end
    mem_ack = 1;
    for (int n = 0; n < 10 && stall; n++) tick;
    mem_ack = 0;
    vecs++; if (stall !== 1'b0 || empty !== 1'b1 || ld_data !== ~32'h200) begin errs++; $display("FAIL ld_release got stall=%b empty=%b data=%h exp 0 1 %h", stall, empty, ld_data, ~32'h200); end
`endif
    ld_valid = 0;
    vecs++; if (log_a.size() != 2 || log_d[0] !== 32'h11 || log_d[1] !== 32'h22) begin errs++; $display("FAIL ld_writes got n=%0d exp 2 writes 11 then 22", log_a.size()); end
  endtask
  task automatic test_wrap;
    int maxc = 0;
    log_a.delete(); log_d.delete();
    mem_ack = 1;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1; st_addr = 32'h400 + 32'(4 * i); st_data = 32'hA0 + 32'(i);
      tick;
      if (int'(dut.count) > maxc) maxc = int'(dut.count);
    end
    st_valid = 0;
    for (int n = 0; n < 20 && !empty; n++) begin
      tick;
      if (int'(dut.count) > maxc) maxc = int'(dut.count);
    end
    mem_ack = 0;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL wrap_drain got empty=%b exp 1", empty); end
    vecs++; if (maxc > 2) begin errs++; $display("FAIL wrap_maxcount got %0d exp <=2", maxc); end
    vecs++; if (log_a.size() != 10) begin errs++; $display("FAIL wrap_nwrites got %0d exp 10", log_a.size()); end
    for (int i = 0; i < 10 && i < log_a.size(); i++) begin
      vecs++;
      if (log_a[i] !== 32'h400 + 32'(4 * i) || log_d[i] !== 32'hA0 + 32'(i)) begin
        errs++; $display("FAIL wrap_order[%0d] got %h/%h exp %h/%h", i, log_a[i], log_d[i], 32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_full;
    test_load_hit;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
